// File: rtl/icu_wide.sv
// Wide MC14500B-style industrial control unit: 16-opcode bit-logic processor on a
// WIDTH-bit result register with per-bit I/O enable masks and an acknowledged store port.
package instructions;
    typedef enum logic [3:0] {
        NOPO = 4'h0, LD = 4'h1, LDC = 4'h2, AND = 4'h3,
        ANDC = 4'h4, OR = 4'h5, ORC = 4'h6, XNOR = 4'h7,
        STO = 4'h8, STOC = 4'h9, IEN = 4'hA, OEN = 4'hB,
        JMP = 4'hC, RTN = 4'hD, SKZ = 4'hE, NOPF = 4'hF
    } instruction_t;
endpackage

module icu_wide
    import instructions::*;
#(
    parameter int WIDTH          = 8,
    parameter bit STALL_ON_WRITE = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  instruction_t       instruction,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [WIDTH-1:0]   data_in,
    output logic [WIDTH-1:0]   data_out,
    output logic               write,
    output logic [WIDTH-1:0]   write_mask,
    input  logic               write_ack,
    output logic               jmp,
    output logic               rtn,
    output logic               flag_o,
    output logic               flag_f,
    output logic [WIDTH-1:0]   rr_out
);

    logic [WIDTH-1:0] rr_q, rr_d;
    logic [WIDTH-1:0] ien_q, ien_d;
    logic [WIDTH-1:0] oen_q, oen_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [WIDTH-1:0] wmask_q, wmask_d;
    logic             skip_q, skip_d;
    logic             write_q, write_d;
    logic             jmp_q, jmp_d;
    logic             rtn_q, rtn_d;
    logic             flago_q, flago_d;
    logic             flagf_q, flagf_d;
    logic             accept;
    logic [WIDTH-1:0] operand;

    assign instr_ready = !rst && !(write_q && STALL_ON_WRITE);
    assign accept      = instr_valid && instr_ready;
    assign operand     = data_in & ien_q;

    always_comb begin
        rr_d    = rr_q;
        ien_d   = ien_q;
        oen_d   = oen_q;
        dout_d  = dout_q;
        wmask_d = wmask_q;
        skip_d  = skip_q;
        jmp_d   = 1'b0;
        rtn_d   = 1'b0;
        flago_d = 1'b0;
        flagf_d = 1'b0;
        // A pending store holds until acknowledged; in pulse mode it always lasts one cycle.
        write_d = STALL_ON_WRITE ? (write_q && !write_ack) : 1'b0;

        if (accept) begin
            if (skip_q) begin
                skip_d = 1'b0;
            end else begin
                case (instruction)
                    NOPO: flago_d = 1'b1;
                    LD:   rr_d = operand;
                    LDC:  rr_d = ~operand;
                    AND:  rr_d = rr_q & operand;
                    ANDC: rr_d = ~rr_q & operand;
                    OR:   rr_d = rr_q | operand;
                    // Disabled input bits read as 1 for ORC rather than 0.
                    ORC:  rr_d = ((~rr_q | data_in) & ien_q) | ~ien_q;
                    XNOR: rr_d = ~rr_q ^ operand;
                    STO, STOC: begin
                        if (oen_q != '0) begin
                            dout_d  = (instruction == STO) ? rr_q : ~rr_q;
                            wmask_d = oen_q;
                            write_d = 1'b1;
                        end
                    end
                    IEN:  ien_d = data_in;
                    OEN:  oen_d = operand;
                    JMP:  jmp_d = 1'b1;
                    RTN: begin
                        rtn_d  = 1'b1;
                        skip_d = 1'b1;
                    end
                    SKZ:  skip_d = (rr_q == '0);
                    NOPF: flagf_d = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q    <= '0;
            ien_q   <= '0;
            oen_q   <= '0;
            dout_q  <= '0;
            wmask_q <= '0;
            skip_q  <= 1'b0;
            write_q <= 1'b0;
            jmp_q   <= 1'b0;
            rtn_q   <= 1'b0;
            flago_q <= 1'b0;
            flagf_q <= 1'b0;
        end else begin
            rr_q    <= rr_d;
            ien_q   <= ien_d;
            oen_q   <= oen_d;
            dout_q  <= dout_d;
            wmask_q <= wmask_d;
            skip_q  <= skip_d;
            write_q <= write_d;
            jmp_q   <= jmp_d;
            rtn_q   <= rtn_d;
            flago_q <= flago_d;
            flagf_q <= flagf_d;
        end
    end

    assign rr_out     = rr_q;
    assign data_out   = dout_q;
    assign write_mask = wmask_q;
    assign write      = write_q;
    assign jmp        = jmp_q;
    assign rtn        = rtn_q;
    assign flag_o     = flago_q;
    assign flag_f     = flagf_q;

endmodule

// File: tb/tb_icu_wide.sv
// Scoreboard bench for icu_wide: directed test-plan sequences followed by random
// instruction streams, checked against an opcode-level reference model.
module tb_icu_wide;
    import instructions::*;

    localparam int W     = 8;
    localparam bit STALL = 1'b1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    instruction_t instruction = NOPO;
    logic         instr_valid = 1'b0;
    logic         instr_ready;
    logic [W-1:0] data_in = '0;
    logic [W-1:0] data_out;
    logic         write;
    logic [W-1:0] write_mask;
    logic         write_ack = 1'b0;
    logic         jmp, rtn, flag_o, flag_f;
    logic [W-1:0] rr_out;

    int checks = 0;
    int errors = 0;
    int ackDelay = 0;
    int writeCycles = 0;

    typedef struct {
        logic [W-1:0] rr, dout, wm;
        logic         wr, jmp, rtn, fo, ff;
    } exp_t;
    exp_t expQ[$];

    logic [W-1:0] mRr = '0, mIen = '0, mOen = '0, mDout = '0, mWm = '0;
    logic         mSkip = 1'b0, mWrite = 1'b0;
    logic         dutAcc = 1'b0;

    icu_wide #(.WIDTH(W), .STALL_ON_WRITE(STALL)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .data_in(data_in), .data_out(data_out),
        .write(write), .write_mask(write_mask), .write_ack(write_ack),
        .jmp(jmp), .rtn(rtn), .flag_o(flag_o), .flag_f(flag_f), .rr_out(rr_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one accepted instruction applied to the architectural state.
    always @(posedge clk) begin
        exp_t e;
        logic [W-1:0] m;
        logic acc;
        if (rst) begin
            mRr = '0; mIen = '0; mOen = '0; mDout = '0; mWm = '0;
            mSkip = 1'b0; mWrite = 1'b0;
        end else begin
            acc = instr_valid && !(mWrite && STALL);
            if (STALL) begin
                if (mWrite && write_ack) mWrite = 1'b0;
            end else begin
                mWrite = 1'b0;
            end
            if (acc) begin
                e.jmp = 0; e.rtn = 0; e.fo = 0; e.ff = 0;
                if (mSkip) begin
                    mSkip = 1'b0;
                end else begin
                    m = data_in & mIen;
                    case (instruction)
                        NOPO: e.fo = 1;
                        NOPF: e.ff = 1;
                        JMP:  e.jmp = 1;
                        RTN:  begin e.rtn = 1; mSkip = 1'b1; end
                        SKZ:  mSkip = (mRr == 0);
                        LD:   mRr = m;
                        LDC:  mRr = ~m;
                        AND:  mRr = mRr & m;
                        ANDC: mRr = ~mRr & m;
                        OR:   mRr = mRr | m;
                        XNOR: mRr = ~(mRr ^ m);
                        ORC:  for (int i = 0; i < W; i++)
                                  mRr[i] = mIen[i] ? (!mRr[i] || data_in[i]) : 1'b1;
                        IEN:  mIen = data_in;
                        OEN:  mOen = m;
                        STO, STOC: if (mOen != 0) begin
                            mDout  = (instruction == STO) ? mRr : ~mRr;
                            mWm    = mOen;
                            mWrite = 1'b1;
                        end
                        default: ;
                    endcase
                end
                e.rr = mRr; e.dout = mDout; e.wm = mWm; e.wr = mWrite;
                expQ.push_back(e);
            end
        end
    end

    // Monitor: notes DUT handshakes and compares on the following falling edge.
    always @(posedge clk) dutAcc = instr_valid && instr_ready;

    always @(negedge clk) begin
        exp_t e;
        if (dutAcc) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_accept", 32'd1, 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("sb_rr", rr_out, e.rr);
                checkOutput("sb_data_out", data_out, e.dout);
                checkOutput("sb_write_mask", write_mask, e.wm);
                checkOutput("sb_write", write, e.wr);
                checkOutput("sb_pulses", {jmp, rtn, flag_o, flag_f}, {e.jmp, e.rtn, e.fo, e.ff});
            end
        end else begin
            checkOutput("idle_rr", rr_out, mRr);
            checkOutput("idle_data_out", data_out, mDout);
            checkOutput("idle_write_mask", write_mask, mWm);
            checkOutput("idle_write", write, mWrite);
            checkOutput("idle_pulses", {jmp, rtn, flag_o, flag_f}, 4'b0);
        end
        checkOutput("ready", instr_ready, !rst && !(mWrite && STALL));
    end

    // Bus model: withholds write_ack for ackDelay cycles of a pending store, random otherwise.
    always @(posedge clk) begin
        #1;
        if (write) begin
            writeCycles++;
            write_ack = (writeCycles > ackDelay);
        end else begin
            writeCycles = 0;
            write_ack = 1'($urandom_range(0, 1));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input instruction_t op, input logic [W-1:0] d);
        int waitCycles = 0;
        instruction = op;
        data_in     = d;
        instr_valid = 1'b1;
        while (!instr_ready && waitCycles < 50) begin
            idle(1);
            waitCycles++;
        end
        if (!instr_ready) begin
            checkOutput("ready_timeout", 32'd0, 32'd1);
        end else begin
            idle(1);
        end
        instr_valid = 1'b0;
    endtask

    task automatic resetDut();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    initial begin
        idle(2);
        checkOutput("reset_rr", rr_out, 0);
        checkOutput("reset_write", write, 0);
        checkOutput("reset_ready", instr_ready, 0);
        rst = 1'b0;
        #1;
        checkOutput("ready_after_reset", instr_ready, 1);

        applyStimulus(IEN, 8'hFF);
        applyStimulus(LD, 8'hA5);
        applyStimulus(OR, 8'h0F);
        checkOutput("or_result", rr_out, 8'hAF);
        checkOutput("no_write", write, 0);

        applyStimulus(IEN, 8'h0F);
        applyStimulus(LD, 8'hFF);
        checkOutput("masked_ld", rr_out, 8'h0F);
        applyStimulus(ORC, 8'h00);
        checkOutput("orc", rr_out, 8'hF0);
        applyStimulus(LDC, 8'hFF);
        checkOutput("ldc", rr_out, 8'hF0);

        ackDelay = 3;
        applyStimulus(IEN, 8'hFF);
        applyStimulus(OEN, 8'hFF);
        applyStimulus(LD, 8'h3C);
        applyStimulus(STO, 8'h00);
        for (int c = 0; c < 4; c++) begin
            checkOutput("stall_write", write, 1);
            checkOutput("stall_data", data_out, 8'h3C);
            checkOutput("stall_mask", write_mask, 8'hFF);
            checkOutput("stall_ready", instr_ready, 0);
            idle(1);
        end
        checkOutput("write_done", write, 0);
        checkOutput("ready_done", instr_ready, 1);
        applyStimulus(STOC, 8'h00);
        checkOutput("stoc_data", data_out, 8'hC3);
        idle(6);

        applyStimulus(IEN, 8'h00);
        applyStimulus(OEN, 8'hFF);
        applyStimulus(STO, 8'h00);
        checkOutput("oen_zero_write", write, 0);
        checkOutput("oen_zero_ready", instr_ready, 1);

        applyStimulus(IEN, 8'hFF);
        applyStimulus(LD, 8'h00);
        applyStimulus(SKZ, 8'h00);
        applyStimulus(LD, 8'hFF);
        checkOutput("skz_taken", rr_out, 8'h00);
        applyStimulus(LD, 8'h01);
        applyStimulus(SKZ, 8'h00);
        applyStimulus(LD, 8'hFF);
        checkOutput("skz_not_taken", rr_out, 8'hFF);
        applyStimulus(RTN, 8'h00);
        checkOutput("rtn_pulse", rtn, 1);
        applyStimulus(JMP, 8'h00);
        checkOutput("jmp_skipped", jmp, 0);
        checkOutput("rtn_cleared", rtn, 0);
        applyStimulus(LD, 8'h5A);
        checkOutput("skip_cleared", rr_out, 8'h5A);

        ackDelay = 100;
        applyStimulus(OEN, 8'hFF);
        applyStimulus(STO, 8'h00);
        idle(1);
        checkOutput("write_pending", write, 1);
        rst = 1'b1;
        idle(1);
        checkOutput("rst_write", write, 0);
        checkOutput("rst_rr", rr_out, 0);
        checkOutput("rst_ready", instr_ready, 0);
        rst = 1'b0;
        #1;
        checkOutput("rst_ready_drop", instr_ready, 1);
        applyStimulus(STO, 8'h00);
        checkOutput("rst_no_write", write, 0);

        for (int n = 0; n < 400; n++) begin
            ackDelay = $urandom_range(0, 3);
            if ($urandom_range(0, 79) == 0) resetDut();
            applyStimulus(instruction_t'($urandom_range(0, 15)), W'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(10);
        checkOutput("queue_drained", expQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/icu_wide.md
Name: icu_wide

Overview:
- Parametrised successor to the 1-bit MC14500B-style industrial control unit. Executes the same 16-opcode `instruction_t` set on a WIDTH-bit result register.
- Per-bit input and output enable masks.
- Single-edge (posedge) pipeline with a valid/ready instruction handshake and an acknowledged store port.
- Sits between the program sequencer (instruction fetch, JMP/RTN handling) and the I/O bus.

Parameters:
- WIDTH, 8: data path width; result register, data_in, data_out, enable masks.
- STALL_ON_WRITE, 1: 1 = a store holds `write` until `write_ack`; 0 = `write` is a one-cycle pulse and `write_ack` is ignored.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- instruction  input  4 (instruction_t)  opcode from the instructions package: NOPO=0, LD=1, LDC=2, AND=3, ANDC=4, OR=5, ORC=6, XNOR=7, STO=8, STOC=9, IEN=A, OEN=B, JMP=C, RTN=D, SKZ=E, NOPF=F.
- instr_valid  input  1  instruction and data_in valid.
- instr_ready  output  1  ICU can accept an instruction this cycle.
- data_in  input  WIDTH  operand, sampled on acceptance.
- data_out  output  WIDTH  store data.
- write  output  1  store request.
- write_mask  output  WIDTH  per-bit output enable for the store (the OEN mask).
- write_ack  input  1  store accepted by the bus.
- jmp, rtn, flag_o, flag_f  output  1  one-cycle opcode pulses.
- rr_out  output  WIDTH  result register.

Behaviour:
- Reset (synchronous): rr, ien_mask, oen_mask, skip, data_out, write_mask are all 0. write, jmp, rtn, flag_o, flag_f are 0. instr_ready is 0 while rst is high and 1 in the first cycle after rst drops.
- Accept = instr_valid & instr_ready. All effects below occur on the accepting posedge and are visible the next cycle, giving 1-cycle latency.
- instr_ready = !rst & !(write & STALL_ON_WRITE).
- Operand: m = data_in & ien_mask.
- Per-bit opcode semantics, bit i:
  - LD: rr = m.
  - LDC: rr = ~m.
  - AND: rr = rr & m.
  - ANDC: rr = ~rr & m.
  - OR: rr = rr | m.
  - ORC: rr[i] = ien_mask[i] ? (~rr[i] | data_in[i]) : 1.
  - XNOR: rr = ~rr ^ m.
  - IEN: ien_mask = data_in (unmasked).
  - OEN: oen_mask = m.
- STO/STOC:
  - If oen_mask != 0: data_out = rr (STO) or ~rr (STOC); write_mask = oen_mask; write = 1.
  - If oen_mask == 0: no write; data_out and write_mask are unchanged.
- Pulses: JMP drives jmp = 1, RTN drives rtn = 1, NOPO drives flag_o = 1, NOPF drives flag_f = 1, each for exactly one cycle. They are 0 in every cycle without a corresponding accepted, unskipped opcode.
- Skip:
  - Accepted RTN sets skip = 1.
  - Accepted SKZ sets skip = 1 if rr == 0 (all bits, pre-instruction value); otherwise skip = 0.
  - The next accepted instruction while skip = 1 is consumed with no effect: no register change, no write, no pulses. skip then clears.
  - A skipped RTN/SKZ does not re-arm skip.
  - skip persists across idle cycles (instr_valid = 0).
- Write handshake, STALL_ON_WRITE = 1:
  - write stays high, with data_out and write_mask stable, until a cycle with write & write_ack. write drops the following cycle.
  - instr_ready is low throughout, so the instruction is stalled.
  - write_ack while write is low is ignored.
- Write handshake, STALL_ON_WRITE = 0:
  - write is high for exactly one cycle per store.
  - Back-to-back stores produce consecutive pulses.
- Reset mid-write: write drops the next cycle, no ack is required, and all state clears.
- Width rules: all ops are bitwise on WIDTH bits; there is no carry or arithmetic.

Test Plan:
- Reset, then IEN data_in=FF, LD data_in=A5, OR data_in=0F -> rr_out=AF the cycle after OR is accepted; write=0 throughout.
- IEN data_in=0F, LD data_in=FF -> rr_out=0F. Then ORC data_in=00 with rr=0F -> rr_out=F0. Then LDC data_in=FF -> rr_out=F0.
- STALL_ON_WRITE=1: OEN mask FF, LD 3C, STO with write_ack held 0 for 3 cycles then 1.
  - Required: write=1, data_out=3C, write_mask=FF for 4 cycles; instr_ready=0 for those 4 cycles; write=0 and ready=1 the next cycle.
  - Then STOC -> data_out=C3.
- OEN with ien_mask=00 leaves oen_mask=00 -> the next STO gives no write and instr_ready stays 1.
- LD 00, SKZ, LD FF -> rr_out stays 00 (LD skipped). Then LD 01, SKZ, LD FF -> rr_out=FF. Then RTN, JMP -> rtn pulses 1 cycle; jmp does not pulse (JMP skipped); skip=0 afterwards.
- Assert rst while write is pending -> next cycle write=0, rr_out=00, instr_ready=0; after rst drops, instr_ready=1 and STO with oen_mask=00 produces no write.
